// File: rtl/sdram_req_ctrl.sv
// User-side burst requester for the SDRAM controller: FIFO-level driven write/read
// grants over a circular region. Define SDRAM_ACK_CHECK_EN for ack_err and a req watchdog.

module sdram_req_ctrl #(
    parameter int unsigned ADDR_W        = 24,
    parameter int unsigned LVL_W         = 11,
    parameter int unsigned RD_FIFO_DEPTH = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sdram_init_done,
    input  logic              cfg_load,
    input  logic [ADDR_W-1:0] cfg_start_addr,
    input  logic [ADDR_W-1:0] cfg_end_addr,
    input  logic [9:0]        cfg_wr_burst,
    input  logic [9:0]        cfg_rd_burst,
    input  logic [LVL_W-1:0]  wr_fifo_used,
    input  logic [LVL_W-1:0]  rd_fifo_used,
    input  logic              sdram_wr_ack,
    input  logic              sdram_rd_ack,
    output logic              sdram_wr_req,
    output logic              sdram_rd_req,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    output logic [ADDR_W-1:0] sdram_rd_addr,
    output logic [9:0]        sdram_wr_burst,
    output logic [9:0]        sdram_rd_burst,
    output logic              wr_fifo_rden,
    output logic              rd_fifo_wren,
    output logic [ADDR_W:0]   fill_cnt,
`ifdef SDRAM_ACK_CHECK_EN
    output logic              ack_err,
`endif
    output logic              busy
);

    localparam int unsigned BURST_W = 10;
    localparam int unsigned CNT_W   = ADDR_W + 2;
    localparam int unsigned SUM_W   = ADDR_W + 1;
    localparam int unsigned CMP_W   = 32;
    localparam logic        GRANT_WR = 1'b1;
    localparam logic        GRANT_RD = 1'b0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_BUSY = 3'd2,
        RD_REQ  = 3'd3,
        RD_BUSY = 3'd4
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   start_addr;
    logic [ADDR_W-1:0]   end_addr;
    logic                last_grant;
    logic                wr_ack_d;
    logic                rd_ack_d;
    logic [BURST_W:0]    ack_cnt;

    logic [CNT_W-1:0]    region_size;
    logic                wr_ok;
    logic                rd_ok;
    logic                grant_wr;
    logic                grant_rd;
    logic [SUM_W-1:0]    wr_sum;
    logic [SUM_W-1:0]    rd_sum;
    logic [ADDR_W-1:0]   wr_next;
    logic [ADDR_W-1:0]   rd_next;

`ifdef SDRAM_ACK_CHECK_EN
    logic [15:0]         wdog;
    logic                stray_ack;
`endif

    assign wr_fifo_rden = sdram_wr_ack;
    assign rd_fifo_wren = sdram_rd_ack;

    // A zero burst length means the block is unconfigured, so it never qualifies.
    assign region_size = CNT_W'(end_addr) - CNT_W'(start_addr) + CNT_W'(1);
    assign wr_ok = sdram_init_done && (sdram_wr_burst != '0)
                && (CMP_W'(wr_fifo_used) >= CMP_W'(sdram_wr_burst))
                && (CNT_W'(fill_cnt) + CNT_W'(sdram_wr_burst) <= region_size);
    assign rd_ok = sdram_init_done && (sdram_rd_burst != '0)
                && (CNT_W'(fill_cnt) >= CNT_W'(sdram_rd_burst))
                && (CMP_W'(rd_fifo_used) + CMP_W'(sdram_rd_burst) <= CMP_W'(RD_FIFO_DEPTH));
    assign grant_wr = wr_ok && (!rd_ok || (last_grant == GRANT_RD));
    assign grant_rd = rd_ok && (!wr_ok || (last_grant == GRANT_WR));

    // Next burst start; wraps to the region start when the burst would pass end_addr.
    assign wr_sum  = {1'b0, sdram_wr_addr} + SUM_W'(sdram_wr_burst);
    assign rd_sum  = {1'b0, sdram_rd_addr} + SUM_W'(sdram_rd_burst);
    assign wr_next = (wr_sum > {1'b0, end_addr}) ? start_addr : wr_sum[ADDR_W-1:0];
    assign rd_next = (rd_sum > {1'b0, end_addr}) ? start_addr : rd_sum[ADDR_W-1:0];

`ifdef SDRAM_ACK_CHECK_EN
    assign stray_ack = (sdram_wr_ack && !((state == WR_REQ) || (state == WR_BUSY)))
                    || (sdram_rd_ack && !((state == RD_REQ) || (state == RD_BUSY)));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            start_addr     <= '0;
            end_addr       <= '0;
            last_grant     <= GRANT_RD;
            wr_ack_d       <= 1'b0;
            rd_ack_d       <= 1'b0;
            ack_cnt        <= '0;
            sdram_wr_req   <= 1'b0;
            sdram_rd_req   <= 1'b0;
            sdram_wr_addr  <= '0;
            sdram_rd_addr  <= '0;
            sdram_wr_burst <= '0;
            sdram_rd_burst <= '0;
            fill_cnt       <= '0;
            busy           <= 1'b0;
`ifdef SDRAM_ACK_CHECK_EN
            wdog           <= '0;
            ack_err        <= 1'b0;
`endif
        end else begin
            wr_ack_d <= sdram_wr_ack;
            rd_ack_d <= sdram_rd_ack;
            case (state)
                IDLE: begin
                    if (cfg_load) begin
                        start_addr     <= cfg_start_addr;
                        end_addr       <= cfg_end_addr;
                        sdram_wr_addr  <= cfg_start_addr;
                        sdram_rd_addr  <= cfg_start_addr;
                        sdram_wr_burst <= cfg_wr_burst;
                        sdram_rd_burst <= cfg_rd_burst;
                        fill_cnt       <= '0;
`ifdef SDRAM_ACK_CHECK_EN
                        ack_err        <= 1'b0;
`endif
                    end else if (grant_wr) begin
                        state        <= WR_REQ;
                        sdram_wr_req <= 1'b1;
                        busy         <= 1'b1;
                        ack_cnt      <= '0;
`ifdef SDRAM_ACK_CHECK_EN
                        wdog         <= '0;
`endif
                    end else if (grant_rd) begin
                        state        <= RD_REQ;
                        sdram_rd_req <= 1'b1;
                        busy         <= 1'b1;
                        ack_cnt      <= '0;
`ifdef SDRAM_ACK_CHECK_EN
                        wdog         <= '0;
`endif
                    end
                end
                WR_REQ: begin
                    if (sdram_wr_ack) begin
                        sdram_wr_req <= 1'b0;
                        ack_cnt      <= (BURST_W+1)'(1);
                        state        <= WR_BUSY;
                    end
`ifdef SDRAM_ACK_CHECK_EN
                    else if (wdog == 16'hFFFF) begin
                        ack_err      <= 1'b1;
                        sdram_wr_req <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        wdog <= wdog + 16'd1;
                    end
`endif
                end
                WR_BUSY: begin
                    if (sdram_wr_ack) begin
                        ack_cnt <= ack_cnt + (BURST_W+1)'(1);
                    end else if (wr_ack_d) begin
                        sdram_wr_addr <= wr_next;
                        fill_cnt      <= fill_cnt + SUM_W'(sdram_wr_burst);
                        last_grant    <= GRANT_WR;
                        busy          <= 1'b0;
                        state         <= IDLE;
`ifdef SDRAM_ACK_CHECK_EN
                        if (ack_cnt != {1'b0, sdram_wr_burst}) ack_err <= 1'b1;
`endif
                    end
                end
                RD_REQ: begin
                    if (sdram_rd_ack) begin
                        sdram_rd_req <= 1'b0;
                        ack_cnt      <= (BURST_W+1)'(1);
                        state        <= RD_BUSY;
                    end
`ifdef SDRAM_ACK_CHECK_EN
                    else if (wdog == 16'hFFFF) begin
                        ack_err      <= 1'b1;
                        sdram_rd_req <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        wdog <= wdog + 16'd1;
                    end
`endif
                end
                RD_BUSY: begin
                    if (sdram_rd_ack) begin
                        ack_cnt <= ack_cnt + (BURST_W+1)'(1);
                    end else if (rd_ack_d) begin
                        sdram_rd_addr <= rd_next;
                        fill_cnt      <= fill_cnt - SUM_W'(sdram_rd_burst);
                        last_grant    <= GRANT_RD;
                        busy          <= 1'b0;
                        state         <= IDLE;
`ifdef SDRAM_ACK_CHECK_EN
                        if (ack_cnt != {1'b0, sdram_rd_burst}) ack_err <= 1'b1;
`endif
                    end
                end
                default: begin
                    state        <= IDLE;
                    sdram_wr_req <= 1'b0;
                    sdram_rd_req <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
`ifdef SDRAM_ACK_CHECK_EN
            if (stray_ack) ack_err <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_sdram_req_ctrl.sv
// Scoreboarded bench for sdram_req_ctrl: a controller model answers each request and
// the expected burst (direction, address, length, resulting fill) is popped and compared.

module tb_sdram_req_ctrl;

    localparam int unsigned ADDR_W = 24;
    localparam int unsigned LVL_W  = 11;

    logic              clk;
    logic              rst_n;
    logic              sdram_init_done;
    logic              cfg_load;
    logic [ADDR_W-1:0] cfg_start_addr;
    logic [ADDR_W-1:0] cfg_end_addr;
    logic [9:0]        cfg_wr_burst;
    logic [9:0]        cfg_rd_burst;
    logic [LVL_W-1:0]  wr_fifo_used;
    logic [LVL_W-1:0]  rd_fifo_used;
    logic              sdram_wr_ack;
    logic              sdram_rd_ack;
    logic              sdram_wr_req;
    logic              sdram_rd_req;
    logic [ADDR_W-1:0] sdram_wr_addr;
    logic [ADDR_W-1:0] sdram_rd_addr;
    logic [9:0]        sdram_wr_burst;
    logic [9:0]        sdram_rd_burst;
    logic              wr_fifo_rden;
    logic              rd_fifo_wren;
    logic [ADDR_W:0]   fill_cnt;
    logic              busy;
`ifdef SDRAM_ACK_CHECK_EN
    logic              ack_err;
`endif

    sdram_req_ctrl #(.ADDR_W(ADDR_W), .LVL_W(LVL_W), .RD_FIFO_DEPTH(1024)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sdram_init_done (sdram_init_done),
        .cfg_load        (cfg_load),
        .cfg_start_addr  (cfg_start_addr),
        .cfg_end_addr    (cfg_end_addr),
        .cfg_wr_burst    (cfg_wr_burst),
        .cfg_rd_burst    (cfg_rd_burst),
        .wr_fifo_used    (wr_fifo_used),
        .rd_fifo_used    (rd_fifo_used),
        .sdram_wr_ack    (sdram_wr_ack),
        .sdram_rd_ack    (sdram_rd_ack),
        .sdram_wr_req    (sdram_wr_req),
        .sdram_rd_req    (sdram_rd_req),
        .sdram_wr_addr   (sdram_wr_addr),
        .sdram_rd_addr   (sdram_rd_addr),
        .sdram_wr_burst  (sdram_wr_burst),
        .sdram_rd_burst  (sdram_rd_burst),
        .wr_fifo_rden    (wr_fifo_rden),
        .rd_fifo_wren    (rd_fifo_wren),
        .fill_cnt        (fill_cnt),
`ifdef SDRAM_ACK_CHECK_EN
        .ack_err         (ack_err),
`endif
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit                is_wr;
        logic [ADDR_W-1:0] addr;
        logic [9:0]        burst;
        logic [ADDR_W:0]   fill_after;
        logic [ADDR_W-1:0] next_addr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model of the region pointers and fill level.
    logic [ADDR_W-1:0] m_start, m_end, m_wr_ptr, m_rd_ptr;
    logic [9:0]        m_wb, m_rb;
    logic [ADDR_W:0]   m_fill;

    function automatic logic [ADDR_W-1:0] m_adv(input logic [ADDR_W-1:0] a, input logic [9:0] b);
        int unsigned s;
        s = int'(a) + int'(b);
        if (s > int'(m_end)) return m_start;
        return ADDR_W'(s);
    endfunction

    task automatic expect_burst(input bit is_wr);
        exp_t e;
        e.is_wr = is_wr;
        if (is_wr) begin
            e.addr      = m_wr_ptr;
            e.burst     = m_wb;
            m_wr_ptr    = m_adv(m_wr_ptr, m_wb);
            m_fill      = m_fill + (ADDR_W+1)'(m_wb);
            e.next_addr = m_wr_ptr;
        end else begin
            e.addr      = m_rd_ptr;
            e.burst     = m_rb;
            m_rd_ptr    = m_adv(m_rd_ptr, m_rb);
            m_fill      = m_fill - (ADDR_W+1)'(m_rb);
            e.next_addr = m_rd_ptr;
        end
        e.fill_after = m_fill;
        sb.push_back(e);
    endtask

    task automatic do_cfg(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] en,
                          input logic [9:0] wb, input logic [9:0] rb);
        cfg_start_addr = s;
        cfg_end_addr   = en;
        cfg_wr_burst   = wb;
        cfg_rd_burst   = rb;
        cfg_load       = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
        m_start = s; m_end = en; m_wb = wb; m_rb = rb;
        m_wr_ptr = s; m_rd_ptr = s; m_fill = '0;
    endtask

    // Controller model: waits for a request, acks after 'latency' cycles, drains/fills FIFOs.
    task automatic serve(input int latency);
        exp_t e;
        bit got, hold_ok, drop_ok;
        int pulses;
        logic [ADDR_W-1:0] a;
        logic [9:0] b;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: no expected burst queued");
            return;
        end
        e = sb.pop_front();
        got = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (sdram_wr_req || sdram_rd_req) begin got = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL req_timeout: no request, expected is_wr=%0d addr=%0d", e.is_wr, e.addr);
            return;
        end
        checks++;
        if ({sdram_wr_req, sdram_rd_req} !== {e.is_wr, ~e.is_wr}) begin
            errors++;
            $display("FAIL req_dir: wr_req=%0b rd_req=%0b expected is_wr=%0d", sdram_wr_req, sdram_rd_req, e.is_wr);
        end
        a = e.is_wr ? sdram_wr_addr : sdram_rd_addr;
        b = e.is_wr ? sdram_wr_burst : sdram_rd_burst;
        checks++;
        if (a !== e.addr) begin
            errors++;
            $display("FAIL burst_addr: got %0d expected %0d", a, e.addr);
        end
        checks++;
        if (b !== e.burst) begin
            errors++;
            $display("FAIL burst_len: got %0d expected %0d", b, e.burst);
        end
        hold_ok = 1'b1;
        for (int k = 0; k < latency; k++) begin
            @(negedge clk);
            if ((e.is_wr ? sdram_wr_req : sdram_rd_req) !== 1'b1 || busy !== 1'b1) hold_ok = 1'b0;
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL req_hold: req/busy not held during ack latency %0d", latency);
        end
        pulses  = 0;
        drop_ok = 1'b1;
        for (int i = 0; i < int'(e.burst); i++) begin
            if (e.is_wr) sdram_wr_ack = 1'b1; else sdram_rd_ack = 1'b1;
            @(negedge clk);
            if (e.is_wr && wr_fifo_rden) begin pulses++; wr_fifo_used = wr_fifo_used - 11'd1; end
            if (!e.is_wr && rd_fifo_wren) begin pulses++; rd_fifo_used = rd_fifo_used + 11'd1; end
            if (sdram_wr_req || sdram_rd_req) drop_ok = 1'b0;
        end
        sdram_wr_ack = 1'b0;
        sdram_rd_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (pulses != int'(e.burst)) begin
            errors++;
            $display("FAIL fifo_pulses: got %0d expected %0d", pulses, e.burst);
        end
        checks++;
        if (!drop_ok) begin
            errors++;
            $display("FAIL req_drop: request still high after first ack");
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_end: got %0b expected 0", busy);
        end
        checks++;
        if (fill_cnt !== e.fill_after) begin
            errors++;
            $display("FAIL fill_cnt: got %0d expected %0d", fill_cnt, e.fill_after);
        end
        a = e.is_wr ? sdram_wr_addr : sdram_rd_addr;
        checks++;
        if (a !== e.next_addr) begin
            errors++;
            $display("FAIL next_addr: got %0d expected %0d", a, e.next_addr);
        end
    endtask

    task automatic expect_quiet(input int cycles, input string name);
        bit q;
        q = 1'b1;
        for (int n = 0; n < cycles; n++) begin
            @(negedge clk);
            if (sdram_wr_req || sdram_rd_req || busy) q = 1'b0;
        end
        checks++;
        if (!q) begin
            errors++;
            $display("FAIL %s: request or busy seen, expected idle", name);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sdram_init_done = 1'b0; cfg_load = 1'b0;
        cfg_start_addr = '0; cfg_end_addr = '0; cfg_wr_burst = '0; cfg_rd_burst = '0;
        wr_fifo_used = '0; rd_fifo_used = '0; sdram_wr_ack = 1'b0; sdram_rd_ack = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sdram_wr_req, sdram_rd_req, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctrl: req/req/busy=%b expected 000", {sdram_wr_req, sdram_rd_req, busy});
        end
        checks++;
        if (sdram_wr_addr !== '0 || sdram_rd_addr !== '0 || fill_cnt !== '0) begin
            errors++;
            $display("FAIL reset_regs: wr_addr=%0d rd_addr=%0d fill=%0d expected 0", sdram_wr_addr, sdram_rd_addr, fill_cnt);
        end
        checks++;
        if (sdram_wr_burst !== '0 || sdram_rd_burst !== '0) begin
            errors++;
            $display("FAIL reset_burst: wr=%0d rd=%0d expected 0", sdram_wr_burst, sdram_rd_burst);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_burst();
        do_cfg(24'd0, 24'd1023, 10'd256, 10'd256);
        wr_fifo_used = 11'd300;
        rd_fifo_used = 11'd1024;
        expect_quiet(10, "init_gate");
        sdram_init_done = 1'b1;
        expect_burst(1'b1);
        serve(3);
        expect_quiet(10, "after_write_quiet");
    endtask

    task automatic test_read_after_write();
        rd_fifo_used = 11'd0;
        expect_burst(1'b0);
        serve(3);
    endtask

    task automatic test_round_robin();
        rd_fifo_used = 11'd1024;
        wr_fifo_used = 11'd512;
        expect_burst(1'b1);
        expect_burst(1'b1);
        serve(2);
        serve(2);
        rd_fifo_used = 11'd0;
        wr_fifo_used = 11'd600;
        expect_burst(1'b0);
        expect_burst(1'b1);
        serve(1);
        serve(1);
        wr_fifo_used = 11'd0;
        rd_fifo_used = 11'd1024;
        expect_quiet(5, "rr_quiet");
    endtask

    task automatic test_wrap_full();
        do_cfg(24'd0, 24'd1023, 10'd256, 10'd256);
        wr_fifo_used = 11'd1024;
        rd_fifo_used = 11'd1024;
        for (int i = 0; i < 4; i++) expect_burst(1'b1);
        for (int i = 0; i < 4; i++) serve(2);
        wr_fifo_used = 11'd1000;
        expect_quiet(20, "full_block");
        wr_fifo_used = 11'd0;
    endtask

    task automatic test_rd_backpressure();
        do_cfg(24'd0, 24'd1023, 10'd256, 10'd256);
        wr_fifo_used = 11'd256;
        rd_fifo_used = 11'd1024;
        expect_burst(1'b1);
        serve(1);
        rd_fifo_used = 11'd900;
        expect_quiet(20, "rd_free_124");
        rd_fifo_used = 11'd769;
        expect_quiet(10, "rd_free_255");
        rd_fifo_used = 11'd768;
        expect_burst(1'b0);
        serve(2);
    endtask

    task automatic test_short_burst();
        do_cfg(24'd8, 24'd11, 10'd1, 10'd1);
        checks++;
        if (sdram_wr_addr !== 24'd8 || sdram_rd_addr !== 24'd8 || sdram_wr_burst !== 10'd1 || sdram_rd_burst !== 10'd1) begin
            errors++;
            $display("FAIL cfg_latch: wr_addr=%0d rd_addr=%0d wb=%0d rb=%0d expected 8 8 1 1",
                     sdram_wr_addr, sdram_rd_addr, sdram_wr_burst, sdram_rd_burst);
        end
        wr_fifo_used = 11'd4;
        rd_fifo_used = 11'd1024;
        for (int i = 0; i < 4; i++) expect_burst(1'b1);
        for (int i = 0; i < 4; i++) serve(0);
        wr_fifo_used = 11'd4;
        expect_quiet(10, "short_full");
        wr_fifo_used = 11'd0;
        rd_fifo_used = 11'd0;
        for (int i = 0; i < 4; i++) expect_burst(1'b0);
        for (int i = 0; i < 4; i++) serve(0);
        expect_quiet(5, "short_empty");
    endtask

    task automatic test_async_reset();
        bit got;
        do_cfg(24'd0, 24'd1023, 10'd256, 10'd256);
        wr_fifo_used = 11'd512;
        rd_fifo_used = 11'd1024;
        expect_burst(1'b1);
        serve(1);
        got = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (sdram_wr_req) begin got = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL rst_req_timeout: second write request not seen");
        end
        sdram_wr_ack = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || fill_cnt !== 25'd256) begin
            errors++;
            $display("FAIL pre_reset: busy=%0b fill=%0d expected 1 256", busy, fill_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sdram_wr_req, sdram_rd_req, busy} !== 3'b000 || fill_cnt !== '0) begin
            errors++;
            $display("FAIL async_rst_ctrl: req/req/busy=%b fill=%0d expected 000 0",
                     {sdram_wr_req, sdram_rd_req, busy}, fill_cnt);
        end
        checks++;
        if (sdram_wr_addr !== '0 || sdram_rd_addr !== '0 || sdram_wr_burst !== '0) begin
            errors++;
            $display("FAIL async_rst_regs: wr_addr=%0d rd_addr=%0d wb=%0d expected 0",
                     sdram_wr_addr, sdram_rd_addr, sdram_wr_burst);
        end
        sdram_wr_ack = 1'b0;
        wr_fifo_used = '0;
        @(negedge clk);
        rst_n = 1'b1;
        expect_quiet(5, "post_reset_quiet");
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_after_write();
        test_round_robin();
        test_wrap_full();
        test_rd_backpressure();
        test_short_burst();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sdram_req_ctrl.md
Name: sdram_req_ctrl

Overview:
- User-side requester for the SDRAM state-machine controller. It is the other end of the controller's req/ack burst handshake.
- Watches the write-FIFO and read-FIFO levels and decides when to issue write or read burst requests. It also generates the burst addresses inside a circular SDRAM region.
- Tracks how many words the SDRAM holds, so it never reads unwritten data and never overwrites unread data.
- Sits between the acquisition FIFOs and the SDRAM controller.

Parameters:
- ADDR_W, 24, SDRAM word address width: bank 2 + row 13 + col 9.
- LVL_W, 11, width of the FIFO level inputs.
- RD_FIFO_DEPTH, 1024, read-FIFO capacity in words.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- sdram_init_done  in  1  controller initialisation complete.
- cfg_load  in  1  one-cycle pulse: latch cfg_* values and clear pointers and fill count.
- cfg_start_addr  in  ADDR_W  first word of the circular region.
- cfg_end_addr  in  ADDR_W  last word of the region, inclusive.
- cfg_wr_burst  in  10  write burst length, 1-512.
- cfg_rd_burst  in  10  read burst length, 1-256.
- wr_fifo_used  in  LVL_W  words waiting in the write FIFO.
- rd_fifo_used  in  LVL_W  words held in the read FIFO.
- sdram_wr_ack  in  1  controller write ack; high for one cycle per word.
- sdram_rd_ack  in  1  controller read ack; high for one cycle per word.
- sdram_wr_req  out  1  write burst request.
- sdram_rd_req  out  1  read burst request.
- sdram_wr_addr  out  ADDR_W  start address of the current write burst.
- sdram_rd_addr  out  ADDR_W  start address of the current read burst.
- sdram_wr_burst  out  10  latched write burst length.
- sdram_rd_burst  out  10  latched read burst length.
- wr_fifo_rden  out  1  equals sdram_wr_ack (combinational).
- rd_fifo_wren  out  1  equals sdram_rd_ack (combinational).
- fill_cnt  out  ADDR_W+1  words currently stored in the SDRAM.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0, except the latched addresses and bursts, which take 0 until the first cfg_load. State is IDLE and last_grant is RD.
- cfg_load:
  - Honoured only in IDLE; ignored otherwise.
  - Sets both address pointers to cfg_start_addr and clears fill_cnt.
  - Latches both burst lengths.
  - The region size (end − start + 1) must be a multiple of both burst lengths. This is a software requirement and is not checked in hardware.
- Eligibility is evaluated only in IDLE with sdram_init_done=1:
  - wr_ok: wr_fifo_used >= wr_burst and fill_cnt + wr_burst <= region size.
  - rd_ok: fill_cnt >= rd_burst and RD_FIFO_DEPTH − rd_fifo_used >= rd_burst.
  - If both are eligible, grant the opposite of last_grant (round-robin). Otherwise grant whichever is eligible.
- State machine: IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY.
  - IDLE → WR_REQ or RD_REQ on grant. The corresponding req goes high in the next cycle.
  - WR_REQ: hold sdram_wr_req=1 until sdram_wr_ack is first seen high. Drop req on the following cycle and go to WR_BUSY.
  - WR_BUSY: count ack cycles. Burst ends on the falling edge of ack (registered ack_d=1, ack=0).
  - At burst end:
    - Address advances by the burst length; if addr + burst > end_addr, it wraps to start_addr.
    - fill_cnt changes by +wr_burst (write) or −rd_burst (read).
    - last_grant is updated and the state returns to IDLE.
  - The RD path is symmetric.
- Request timing:
  - Requests are never asserted while busy.
  - Read and write requests are never asserted simultaneously.
  - The controller's ack latency (any number of cycles) is tolerated.
- If sdram_init_done drops mid-burst, the current burst completes normally; no new grant is made until it returns high.
- Asynchronous reset mid-burst returns everything to reset values immediately. SDRAM data is then considered lost.
- fill_cnt never underflows or overflows, because eligibility guarantees the bounds.

Optional Feature:
- Macro: SDRAM_ACK_CHECK_EN.
- When defined:
  - Adds output ack_err (1 bit, sticky, cleared only by reset or cfg_load).
  - ack_err sets if the ack count at burst end differs from the latched burst length.
  - ack_err also sets if an ack arrives in IDLE or in the opposite-direction state.
  - Adds a 16-bit req-to-first-ack watchdog; expiry at 65535 cycles sets ack_err and forces IDLE with req dropped.
- When undefined: no ack_err port and no watchdog. Acks are trusted and behaviour is otherwise identical.

Test Plan:
- Write burst: cfg start=0, end=1023, wr_burst=256, rd_burst=256; wr_fifo_used=300; ack delayed 3 cycles → one wr_req; exactly 256 wr_fifo_rden pulses; wr_addr becomes 256; fill_cnt=256; no rd_req until eligible.
- Read after write: continuing from the previous case with rd_fifo_used=0 → rd_req at addr 0; 256 rd_fifo_wren pulses; fill_cnt=0; rd_addr=256.
- Round-robin: fill_cnt=512 and wr_fifo_used=600 with last_grant=WR → read granted first, then write.
- Wrap and full:
  - Write 4×256 bursts → wr_addr wraps to 0 and fill_cnt=1024.
  - Next write is blocked (fill + 256 > 1024) even with wr_fifo_used=1000.
- Read-FIFO backpressure: fill_cnt=256, rd_fifo_used=900 (free 124 < 256) → no rd_req until rd_fifo_used ≤ 768.
- Reset and ack check: assert rst_n=0 during WR_BUSY → req, fill_cnt and pointers return to 0 asynchronously. With SDRAM_ACK_CHECK_EN, delivering 255 acks for a 256 burst → ack_err=1.
